temp_capture_log: RTL and testbench

Parametrised successor to the fixed 4-bit temperature/measurement-system capture register. Inputs are captured into a staging register on `ld` and committed on `st` into a DEPTH-entry circular history buffer. The buffer is read out through a show-ahead pop interface. The block also keeps running min/max of committed samples and sticky overflow/underflow flags. It sits between the sensor input switches and the display/format logic.

---
 rtl/temp_log_pkg.sv | 17 +
 rtl/temp_capture_log_if.sv | 40 ++++
 rtl/sync_fifo.sv | 64 ++++++
 rtl/temp_capture_log.sv | 119 +++++++++++
 tb/tb_temp_capture_log.sv | 205 ++++++++++++++++++++
 5 files changed

// File: rtl/temp_log_pkg.sv
// Shared constants and types for the temperature capture/log block.
package temp_log_pkg;

    localparam int unsigned DefDataW = 4;
    localparam int unsigned DefSysW  = 2;

    localparam logic [1:0] SYS_CEL  = 2'b00;
    localparam logic [1:0] SYS_FAH  = 2'b01;
    localparam logic [1:0] SYS_KEL  = 2'b10;
    localparam logic [1:0] SYS_RSVD = 2'b11;

    typedef enum logic {
        S_IDLE,
        S_HELD
    } stage_state_e;

endpackage

// File: rtl/temp_capture_log_if.sv
// Sample/control bus between the sensor front end and the capture log.
interface temp_capture_log_if #(
    parameter int unsigned DATA_W = 4,
    parameter int unsigned SYS_W  = 2,
    parameter int unsigned DEPTH  = 8
);
    localparam int unsigned CNT_W = $clog2(DEPTH) + 1;

    logic [DATA_W-1:0] temp_in;
    logic [SYS_W-1:0]  sys_in;
    logic              ld;
    logic              st;
    logic              rd;
    logic [DATA_W-1:0] stage_temp;
    logic [SYS_W-1:0]  stage_sys;
    logic              stage_vld;
    logic [DATA_W-1:0] head_temp;
    logic [SYS_W-1:0]  head_sys;
    logic              empty;
    logic              full;
    logic [CNT_W-1:0]  count;
    logic [DATA_W-1:0] min_temp;
    logic [DATA_W-1:0] max_temp;
    logic              stats_vld;
    logic              ovf;
    logic              udf;

    modport master (
        output temp_in, sys_in, ld, st, rd,
        input  stage_temp, stage_sys, stage_vld, head_temp, head_sys, empty, full, count,
               min_temp, max_temp, stats_vld, ovf, udf
    );

    modport slave (
        input  temp_in, sys_in, ld, st, rd,
        output stage_temp, stage_sys, stage_vld, head_temp, head_sys, empty, full, count,
               min_temp, max_temp, stats_vld, ovf, udf
    );

endinterface

// File: rtl/sync_fifo.sv
// Circular buffer with show-ahead head; a push into a full buffer is dropped
// unless a pop succeeds in the same cycle.
module sync_fifo #(
    parameter int unsigned WIDTH = 6,
    parameter int unsigned DEPTH = 8
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic                     push_i,
    input  logic [WIDTH-1:0]         data_i,
    input  logic                     pop_i,
    output logic [WIDTH-1:0]         head_o,
    output logic [$clog2(DEPTH):0]   count_o,
    output logic                     full_o,
    output logic                     empty_o,
    output logic                     push_ok_o,
    output logic                     drop_o,
    output logic                     pop_err_o
);
    localparam int unsigned PtrW = $clog2(DEPTH);
    localparam int unsigned CntW = PtrW + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PtrW-1:0]  wptr_q, wptr_d;
    logic [PtrW-1:0]  rptr_q, rptr_d;
    logic [CntW-1:0]  count_q, count_d;
    logic             pop_ok;
    logic             push_ok;

    always_comb begin
        empty_o   = (count_q == '0);
        full_o    = (count_q == CntW'(DEPTH));
        pop_ok    = pop_i & ~empty_o;
        // A same-cycle pop frees the slot, so a push into a full buffer still lands.
        push_ok   = push_i & (~full_o | pop_ok);
        drop_o    = push_i & ~push_ok;
        pop_err_o = pop_i & empty_o;
        push_ok_o = push_ok;
        wptr_d    = push_ok ? wptr_q + PtrW'(1) : wptr_q;
        rptr_d    = pop_ok ? rptr_q + PtrW'(1) : rptr_q;
        count_d   = count_q + CntW'(push_ok) - CntW'(pop_ok);
        head_o    = empty_o ? '0 : mem_q[rptr_q];
        count_o   = count_q;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
        end else begin
            wptr_q  <= wptr_d;
            rptr_q  <= rptr_d;
            count_q <= count_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (push_ok && !rst_i) begin
            mem_q[wptr_q] <= data_i;
        end
    end

endmodule

// File: rtl/temp_capture_log.sv
// Staging register, history buffer, running min/max and sticky error flags
// for captured temperature samples.
module temp_capture_log
    import temp_log_pkg::*;
#(
    parameter int unsigned DATA_W = DefDataW,
    parameter int unsigned SYS_W  = DefSysW,
    parameter int unsigned DEPTH  = 8
) (
    input  logic              clk,
    input  logic              clr,
    temp_capture_log_if.slave bus
);
    localparam int unsigned EntW = DATA_W + SYS_W;

    stage_state_e      state_q, state_d;
    logic [DATA_W-1:0] stage_temp_q, stage_temp_d;
    logic [SYS_W-1:0]  stage_sys_q, stage_sys_d;
    logic [DATA_W-1:0] min_q, min_d;
    logic [DATA_W-1:0] max_q, max_d;
    logic              stats_vld_q, stats_vld_d;
    logic              ovf_q, ovf_d;
    logic              udf_q, udf_d;

    logic              push;
    logic              push_ok;
    logic              drop;
    logic              pop_err;
    logic [EntW-1:0]   head;

    always_comb begin
        state_d      = state_q;
        stage_temp_d = stage_temp_q;
        stage_sys_d  = stage_sys_q;
        push         = 1'b0;
        if (bus.ld) begin
            // Load with a concurrent store commits the old value first.
            push         = (state_q == S_HELD) && bus.st;
            stage_temp_d = bus.temp_in;
            stage_sys_d  = bus.sys_in;
            state_d      = S_HELD;
        end else if (bus.st && state_q == S_HELD) begin
            push    = 1'b1;
            state_d = S_IDLE;
        end
    end

    always_comb begin
        min_d       = min_q;
        max_d       = max_q;
        stats_vld_d = stats_vld_q;
        if (push_ok) begin
            stats_vld_d = 1'b1;
            if (!stats_vld_q) begin
                min_d = stage_temp_q;
                max_d = stage_temp_q;
            end else begin
                if (stage_temp_q < min_q) min_d = stage_temp_q;
                if (stage_temp_q > max_q) max_d = stage_temp_q;
            end
        end
        ovf_d = ovf_q | drop;
        udf_d = udf_q | pop_err;
    end

    always_ff @(posedge clk) begin
        if (clr) begin
            state_q      <= S_IDLE;
            stage_temp_q <= '0;
            stage_sys_q  <= '0;
            min_q        <= '0;
            max_q        <= '0;
            stats_vld_q  <= 1'b0;
            ovf_q        <= 1'b0;
            udf_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            stage_temp_q <= stage_temp_d;
            stage_sys_q  <= stage_sys_d;
            min_q        <= min_d;
            max_q        <= max_d;
            stats_vld_q  <= stats_vld_d;
            ovf_q        <= ovf_d;
            udf_q        <= udf_d;
        end
    end

    sync_fifo #(
        .WIDTH (EntW),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk_i     (clk),
        .rst_i     (clr),
        .push_i    (push),
        .data_i    ({stage_temp_q, stage_sys_q}),
        .pop_i     (bus.rd),
        .head_o    (head),
        .count_o   (bus.count),
        .full_o    (bus.full),
        .empty_o   (bus.empty),
        .push_ok_o (push_ok),
        .drop_o    (drop),
        .pop_err_o (pop_err)
    );

    always_comb begin
        bus.stage_temp = stage_temp_q;
        bus.stage_sys  = stage_sys_q;
        bus.stage_vld  = (state_q == S_HELD);
        bus.head_temp  = head[EntW-1:SYS_W];
        bus.head_sys   = head[SYS_W-1:0];
        bus.min_temp   = min_q;
        bus.max_temp   = max_q;
        bus.stats_vld  = stats_vld_q;
        bus.ovf        = ovf_q;
        bus.udf        = udf_q;
    end

endmodule

// File: tb/tb_temp_capture_log.sv
// Directed and randomized checks of temp_capture_log against a queue-based model.
module tb_temp_capture_log;
    localparam int unsigned DW = 4;
    localparam int unsigned SW = 2;
    localparam int unsigned DP = 8;

    logic clk = 1'b0;
    logic clr = 1'b1;
    always #5 clk = ~clk;

    temp_capture_log_if #(.DATA_W(DW), .SYS_W(SW), .DEPTH(DP)) bus ();

    temp_capture_log #(.DATA_W(DW), .SYS_W(SW), .DEPTH(DP)) dut (
        .clk (clk),
        .clr (clr),
        .bus (bus)
    );

    int n_total = 0;
    int n_pass  = 0;
    bit chk_en  = 1'b0;

    // Behavioural model: queue of {temp, sys}, staging value and stats.
    logic [5:0] mq[$];
    bit         m_vld = 1'b0;
    logic [3:0] m_stemp = '0;
    logic [1:0] m_ssys = '0;
    logic [3:0] m_min = '0;
    logic [3:0] m_max = '0;
    bit         m_stats = 1'b0;
    bit         m_ovf = 1'b0;
    bit         m_udf = 1'b0;

    task automatic check(input string name, input int got, input int exp);
        n_total++;
        if (got !== exp) $display("FAIL %s: got %0d expected %0d at %0t", name, got, exp, $time);
        else n_pass++;
    endtask

    always @(posedge clk) begin
        bit       commit;
        logic [5:0] cval;
        if (clr) begin
            mq.delete();
            m_vld = 0; m_stemp = 0; m_ssys = 0;
            m_min = 0; m_max = 0; m_stats = 0; m_ovf = 0; m_udf = 0;
        end else begin
            commit = bus.st && m_vld;
            cval   = {m_stemp, m_ssys};
            if (bus.rd) begin
                if (mq.size() > 0) void'(mq.pop_front());
                else m_udf = 1;
            end
            if (commit) begin
                if (mq.size() < DP) begin
                    mq.push_back(cval);
                    if (!m_stats) begin
                        m_min = cval[5:2]; m_max = cval[5:2]; m_stats = 1;
                    end else begin
                        if (cval[5:2] < m_min) m_min = cval[5:2];
                        if (cval[5:2] > m_max) m_max = cval[5:2];
                    end
                end else begin
                    m_ovf = 1;
                end
            end
            if (bus.ld) begin
                m_stemp = bus.temp_in; m_ssys = bus.sys_in; m_vld = 1;
            end else if (bus.st) begin
                m_vld = 0;
            end
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            check("m_stage_temp", bus.stage_temp, m_stemp);
            check("m_stage_sys", bus.stage_sys, m_ssys);
            check("m_stage_vld", bus.stage_vld, m_vld);
            check("m_count", bus.count, mq.size());
            check("m_empty", bus.empty, mq.size() == 0);
            check("m_full", bus.full, mq.size() == DP);
            check("m_head_temp", bus.head_temp, mq.size() > 0 ? mq[0][5:2] : 0);
            check("m_head_sys", bus.head_sys, mq.size() > 0 ? mq[0][1:0] : 0);
            check("m_min", bus.min_temp, m_min);
            check("m_max", bus.max_temp, m_max);
            check("m_stats_vld", bus.stats_vld, m_stats);
            check("m_ovf", bus.ovf, m_ovf);
            check("m_udf", bus.udf, m_udf);
        end
    end

    // Drive one cycle's inputs (called at a falling edge) and return at the next one.
    task automatic tick(input bit c, input bit l, input bit s, input bit r,
                        input logic [3:0] t = 4'h0, input logic [1:0] y = 2'b00);
        clr = c; bus.ld = l; bus.st = s; bus.rd = r; bus.temp_in = t; bus.sys_in = y;
        @(negedge clk);
    endtask

    task automatic commit(input logic [3:0] t, input logic [1:0] y);
        tick(0, 1, 0, 0, t, y);
        tick(0, 0, 1, 0);
    endtask

    initial begin
        bus.ld = 0; bus.st = 0; bus.rd = 0; bus.temp_in = 0; bus.sys_in = 0;
        @(negedge clk);
        tick(1, 0, 0, 0);
        chk_en = 1'b1;
        check("rst_empty", bus.empty, 1);
        check("rst_count", bus.count, 0);
        check("rst_stats", bus.stats_vld, 0);
        check("rst_vld", bus.stage_vld, 0);

        // Load then store a single sample.
        tick(0, 1, 0, 0, 4'h9, 2'b01);
        check("t1_stage_temp", bus.stage_temp, 9);
        check("t1_stage_sys", bus.stage_sys, 1);
        check("t1_stage_vld", bus.stage_vld, 1);
        check("t1_empty", bus.empty, 1);
        tick(0, 0, 1, 0);
        check("t1_head_temp", bus.head_temp, 9);
        check("t1_head_sys", bus.head_sys, 1);
        check("t1_count", bus.count, 1);
        check("t1_vld", bus.stage_vld, 0);
        check("t1_min", bus.min_temp, 9);
        check("t1_max", bus.max_temp, 9);

        // Order and min/max, then underflow.
        tick(1, 0, 0, 0);
        commit(4'h3, 2'b00); commit(4'hC, 2'b10); commit(4'h1, 2'b11);
        check("t2_min", bus.min_temp, 1);
        check("t2_max", bus.max_temp, 12);
        check("t2_head0", bus.head_temp, 3);
        tick(0, 0, 0, 1);
        check("t2_head1", bus.head_temp, 12);
        tick(0, 0, 0, 1);
        check("t2_head2", bus.head_temp, 1);
        tick(0, 0, 0, 1);
        check("t2_empty", bus.empty, 1);
        check("t2_head_zero", bus.head_temp, 0);
        check("t2_udf_clear", bus.udf, 0);
        tick(0, 0, 0, 1);
        check("t2_udf", bus.udf, 1);

        // Full buffer: dropped commit, then commit with simultaneous pop.
        tick(1, 0, 0, 0);
        for (int i = 0; i < 8; i++) commit(4'(i + 2), 2'b00);
        check("t3_full", bus.full, 1);
        check("t3_count", bus.count, 8);
        commit(4'hF, 2'b01);
        check("t3_ovf", bus.ovf, 1);
        check("t3_count_drop", bus.count, 8);
        check("t3_max_kept", bus.max_temp, 9);
        tick(1, 0, 0, 0);
        for (int i = 0; i < 8; i++) commit(4'(i + 2), 2'b00);
        tick(0, 1, 0, 0, 4'hF, 2'b01);
        tick(0, 0, 1, 1);
        check("t3_count_rd", bus.count, 8);
        check("t3_no_ovf", bus.ovf, 0);
        for (int i = 0; i < 7; i++) tick(0, 0, 0, 1);
        check("t3_newest", bus.head_temp, 15);
        check("t3_last_count", bus.count, 1);

        // ld+st together, then st in idle.
        tick(1, 0, 0, 0);
        tick(0, 1, 0, 0, 4'h5, 2'b00);
        tick(0, 1, 1, 0, 4'h7, 2'b00);
        check("t4_head", bus.head_temp, 5);
        check("t4_stage", bus.stage_temp, 7);
        check("t4_vld", bus.stage_vld, 1);
        tick(0, 0, 1, 0);
        check("t4_count2", bus.count, 2);
        tick(0, 0, 1, 0);
        check("t4_idle_st", bus.count, 2);

        // clr mid-operation beats a pending store.
        tick(1, 0, 0, 0);
        for (int i = 0; i < 9; i++) commit(4'(i), 2'b10);
        for (int i = 0; i < 4; i++) tick(0, 0, 0, 1);
        tick(0, 1, 0, 0, 4'hA, 2'b01);
        check("t5_pre_count", bus.count, 4);
        check("t5_pre_ovf", bus.ovf, 1);
        tick(1, 0, 1, 0);
        check("t5_count", bus.count, 0);
        check("t5_ovf", bus.ovf, 0);
        check("t5_vld", bus.stage_vld, 0);
        check("t5_stats", bus.stats_vld, 0);
        check("t5_max", bus.max_temp, 0);

        // Randomized traffic against the model.
        for (int i = 0; i < 3000; i++) begin
            tick(($urandom_range(0, 199) == 0),
                 ($urandom_range(0, 99) < 40),
                 ($urandom_range(0, 99) < 40),
                 ($urandom_range(0, 99) < 30),
                 4'($urandom), 2'($urandom));
        end
        tick(0, 0, 0, 0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
